// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_pkg;

  localparam int c_DEBOUNCE_LIMIT_10MS = 1000000;
  localparam int c_TEST_DEBOUNCE_LIMIT = 10;

  // Width of a counter that must hold values up to limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser chain, stability counter, debounced level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = c_DEBOUNCE_LIMIT_10MS,
  parameter int   SYNC_STAGES    = 2,
  parameter logic RESET_STATE    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic enable,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic qualify
);

  localparam int CNT_W = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       count;
  logic                   sync_n;

  assign sync_n = sync_q[SYNC_STAGES-1];

  // High on the edge where the level flips; lets the bank register its summary in step with the pulses.
  assign qualify = enable && (sync_n != stable) && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_STATE}};
      count  <= '0;
      stable <= RESET_STATE;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (!enable || (sync_n == stable)) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync_n;
        count  <= '0;
        rise   <= sync_n;
        fall   <= ~sync_n;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers with a registered any-change flag aligned to the pulses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   NUM_CH         = 4,
  parameter int   DEBOUNCE_LIMIT = c_DEBOUNCE_LIMIT_10MS,
  parameter int   SYNC_STAGES    = 2,
  parameter logic RESET_STATE    = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Enable,
  output logic [NUM_CH-1:0] o_Stable,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change
);

  logic [NUM_CH-1:0] qualify;

  for (genvar n = 0; n < NUM_CH; n++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES),
      .RESET_STATE    (RESET_STATE)
    ) u_ch (
      .clk     (i_Clk),
      .rst     (i_Reset),
      .raw     (i_Switch[n]),
      .enable  (i_Enable[n]),
      .stable  (o_Stable[n]),
      .rise    (o_Rise[n]),
      .fall    (o_Fall[n]),
      .qualify (qualify[n])
    );
  end

  // Built from the per-channel flip conditions so it lands in the same cycle as the pulses.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Any_Change <= 1'b0;
    end else begin
      o_Any_Change <= |qualify;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a 10-cycle window and two synchroniser stages.
module tb_debounce_bank;

  localparam int NUM_CH = 4;
  localparam int LIMIT  = 10;
  localparam int SYNC   = 2;
  localparam int FLIP   = SYNC + LIMIT;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              any;

  logic [12:0] obs;
  logic [12:0] exp_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_CH         (NUM_CH),
    .DEBOUNCE_LIMIT (LIMIT),
    .SYNC_STAGES    (SYNC),
    .RESET_STATE    (1'b0)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Switch     (sw),
    .i_Enable     (en),
    .o_Stable     (stable),
    .o_Rise       (rise),
    .o_Fall       (fall),
    .o_Any_Change (any)
  );

  // Advance n active edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet_reset();
    rst = 1'b1;
    sw  = '0;
    en  = '1;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = '0;
    en  = '1;
    #1;
    obs = {stable, rise, fall, any};
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_assert: got %b want %b", obs, 13'd0);
    end
    tick(2);
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      obs = {stable, rise, fall, any};
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL reset_low_quiet cycle %0d: got %b want %b", i, obs, 13'd0);
      end
    end
    rst = 1'b1;
    sw  = 4'b1111;
    tick(2);
    obs = {stable, rise, fall, any};
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_high_held: got %b want %b", obs, 13'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= FLIP + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {(i >= FLIP) ? 4'b1111 : 4'b0000, (i == FLIP) ? 4'b1111 : 4'b0000, 4'b0000, (i == FLIP)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_high_release edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_rise();
    quiet_reset();
    sw = 4'b0001;
    for (int i = 1; i <= FLIP + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {3'b000, i >= FLIP, 3'b000, i == FLIP, 4'b0000, i == FLIP};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch0_rise edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    // ch0 is already high; ch1 bounces and must never qualify.
    for (int i = 0; i < 36; i++) begin
      sw[1] = (i < 9) || (i >= 12 && i < 21);
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {4'b0001, 4'b0000, 4'b0000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch1_bounce cycle %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // A clean step now needs the full window, proving the counter was back at zero.
    sw[1] = 1'b1;
    for (int i = 1; i <= FLIP + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {2'b00, i >= FLIP, 1'b1, 2'b00, i == FLIP, 1'b0, 4'b0000, i == FLIP};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch1_clean_after_bounce edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_fall();
    sw[2] = 1'b1;
    tick(FLIP + 2);
    obs = {stable, rise, fall, any};
    checks++;
    if (obs !== {4'b0111, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL ch2_settled_high: got %b want %b", obs, {4'b0111, 9'd0});
    end
    sw[2] = 1'b0;
    for (int i = 1; i <= FLIP + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {1'b0, i < FLIP, 2'b11, 4'b0000, 1'b0, i == FLIP, 2'b00, i == FLIP};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch2_fall edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_enable();
    en[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sw[3] = (i < 20) || (i >= 30);
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {4'b0011, 4'b0000, 4'b0000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch3_disabled cycle %0d: got %b want %b", i, obs, exp_v);
      end
    end
    en[3] = 1'b1;
    for (int i = 1; i <= LIMIT + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {i >= LIMIT, 3'b011, i == LIMIT, 3'b000, 4'b0000, i == LIMIT};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch3_reenable edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    quiet_reset();
    sw = 4'b1110;
    tick(FLIP + 2);
    obs = {stable, rise, fall, any};
    checks++;
    if (obs !== {4'b1110, 9'd0}) begin
      errors++;
      $display("FAIL pre_reset_state: got %b want %b", obs, {4'b1110, 9'd0});
    end
    sw = 4'b1111;
    // After SYNC + 7 edges the ch0 counter holds 7.
    tick(SYNC + 7);
    #3;
    rst = 1'b1;
    #1;
    obs = {stable, rise, fall, any};
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got %b want %b", obs, 13'd0);
    end
    tick(1);
    rst = 1'b0;
    for (int i = 1; i <= FLIP + 1; i++) begin
      tick(1);
      obs   = {stable, rise, fall, any};
      exp_v = {(i >= FLIP) ? 4'b1111 : 4'b0000, (i == FLIP) ? 4'b1111 : 4'b0000, 4'b0000, (i == FLIP)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset_window edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    en  = '1;
    test_reset();
    test_rise();
    test_bounce();
    test_fall();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
